// File: rtl/ucsbece154a_defines.sv
// Shared encodings for the multicycle RISC-V controller.
// Define UCSBECE154A_LUI_EN to add the LUI state.
package ucsbece154a_defines;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
`ifdef UCSBECE154A_LUI_EN
        , LUI    = 4'd11
`endif
    } statetype_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/ucsbece154a_aludec.sv
// Combinational ALU decoder shared by the single- and multicycle controllers.
module ucsbece154a_aludec
    import ucsbece154a_defines::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type sub from addi with imm[10] set
                    F3_ADD:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:  alu_control = ALU_SLT;
                    F3_OR:   alu_control = ALU_OR;
                    F3_AND:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RISC-V control FSM (lw, sw, R, I-ALU, beq, jal).
// Define UCSBECE154A_LUI_EN to also support lui.
module ucsbece154a_mc_controller
    import ucsbece154a_defines::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       Zero_i,
    output logic       PCWrite_o,
    output logic       AdrSrc_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ImmSrc_o,
    output logic [2:0] ALUControl_o,
    output logic       RegWrite_o
);

    statetype_t state;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    case (op_i)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECUTER;
                        OP_IALU:      state <= EXECUTEI;
                        OP_BEQ:       state <= BEQ;
                        OP_JAL:       state <= JAL;
`ifdef UCSBECE154A_LUI_EN
                        OP_LUI:       state <= LUI;
`endif
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (op_i == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: state <= FETCH;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
                JAL:      state <= ALUWB;
`ifdef UCSBECE154A_LUI_EN
                LUI:      state <= FETCH;
`endif
                default:  state <= FETCH;
            endcase
        end
    end

    // Outputs are held at their idle values for as long as reset is high
    always_comb begin
        pc_update   = 1'b0;
        branch      = 1'b0;
        alu_op      = ALUOP_ADD;
        AdrSrc_o    = 1'b0;
        MemWrite_o  = 1'b0;
        IRWrite_o   = 1'b0;
        ResultSrc_o = RES_ALUOUT;
        ALUSrcA_o   = SRCA_PC;
        ALUSrcB_o   = SRCB_WD;
        ImmSrc_o    = IMM_I;
        RegWrite_o  = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    IRWrite_o   = 1'b1;
                    ALUSrcB_o   = SRCB_FOUR;
                    ResultSrc_o = RES_ALURES;
                    pc_update   = 1'b1;
                end
                DECODE: begin
                    ALUSrcA_o = SRCA_OLDPC;
                    ALUSrcB_o = SRCB_IMM;
                    ImmSrc_o  = (op_i == OP_JAL) ? IMM_J : IMM_B;
                end
                MEMADR: begin
                    ALUSrcA_o = SRCA_RD1;
                    ALUSrcB_o = SRCB_IMM;
                    ImmSrc_o  = (op_i == OP_LW) ? IMM_I : IMM_S;
                end
                MEMREAD: begin
                    AdrSrc_o = 1'b1;
                end
                MEMWB: begin
                    ResultSrc_o = RES_DATA;
                    RegWrite_o  = 1'b1;
                end
                MEMWRITE: begin
                    AdrSrc_o   = 1'b1;
                    MemWrite_o = 1'b1;
                end
                EXECUTER: begin
                    ALUSrcA_o = SRCA_RD1;
                    alu_op    = ALUOP_FUNCT;
                end
                EXECUTEI: begin
                    ALUSrcA_o = SRCA_RD1;
                    ALUSrcB_o = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                end
                ALUWB: begin
                    RegWrite_o = 1'b1;
                end
                BEQ: begin
                    ALUSrcA_o = SRCA_RD1;
                    alu_op    = ALUOP_SUB;
                    branch    = 1'b1;
                end
                JAL: begin
                    ALUSrcA_o = SRCA_OLDPC;
                    ALUSrcB_o = SRCB_FOUR;
                    pc_update = 1'b1;
                end
`ifdef UCSBECE154A_LUI_EN
                LUI: begin
                    ImmSrc_o    = IMM_U;
                    ResultSrc_o = RES_IMM;
                    RegWrite_o  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign PCWrite_o = pc_update | (branch & Zero_i);

    ucsbece154a_aludec u_aludec (
        .alu_op      (alu_op),
        .funct3      (funct3_i),
        .funct7b5    (funct7b5_i),
        .op5         (op_i[5]),
        .alu_control (ALUControl_o)
    );

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// Directed-vector bench for the multicycle controller.
module tb_ucsbece154a_mc_controller;
    import ucsbece154a_defines::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op_i = 7'b0000011;
    logic [2:0] funct3_i = 3'b000;
    logic       funct7b5_i = 1'b0;
    logic       Zero_i = 1'b0;
    logic       PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, RegWrite_o;
    logic [1:0] ResultSrc_o, ALUSrcA_o, ALUSrcB_o;
    logic [2:0] ImmSrc_o, ALUControl_o;

    int checks = 0;
    int errors = 0;

    ucsbece154a_mc_controller dut (
        .clk          (clk),
        .reset        (reset),
        .op_i         (op_i),
        .funct3_i     (funct3_i),
        .funct7b5_i   (funct7b5_i),
        .Zero_i       (Zero_i),
        .PCWrite_o    (PCWrite_o),
        .AdrSrc_o     (AdrSrc_o),
        .MemWrite_o   (MemWrite_o),
        .IRWrite_o    (IRWrite_o),
        .ResultSrc_o  (ResultSrc_o),
        .ALUSrcA_o    (ALUSrcA_o),
        .ALUSrcB_o    (ALUSrcB_o),
        .ImmSrc_o     (ImmSrc_o),
        .ALUControl_o (ALUControl_o),
        .RegWrite_o   (RegWrite_o)
    );

    always #5 clk = ~clk;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, SrcA, SrcB, ImmSrc, ALUCtl, RegWrite}
    logic [16:0] outs;
    assign outs = {PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o,
                   ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ALUControl_o, RegWrite_o};

    function automatic logic [16:0] v(
        input logic pcw, input logic adr, input logic mw, input logic irw,
        input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
        input logic [2:0] imm, input logic [2:0] alu, input logic rw);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [16:0] exp);
        @(negedge clk);
        check(tag, {15'b0, outs}, {15'b0, exp});
    endtask

    // FETCH is checked, then the new instruction fields appear in IR
    task automatic start(input string tag, input logic [6:0] op,
                         input logic [2:0] f3, input logic f7, input logic z);
        step({tag, ".fetch"}, v(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        op_i       = op;
        funct3_i   = f3;
        funct7b5_i = f7;
        Zero_i     = z;
    endtask

    task automatic decode(input string tag, input logic [2:0] imm);
        step({tag, ".decode"}, v(0,0,0,0,2'b00,2'b01,2'b01,imm,3'b000,0));
    endtask

    task automatic run_alu(input string tag, input logic [6:0] op,
                           input logic [2:0] f3, input logic f7,
                           input logic [2:0] aluc);
        start(tag, op, f3, f7, 1'b0);
        decode(tag, 3'b010);
        if (op == 7'b0110011)
            step({tag, ".execr"}, v(0,0,0,0,2'b00,2'b10,2'b00,3'b000,aluc,0));
        else
            step({tag, ".execi"}, v(0,0,0,0,2'b00,2'b10,2'b01,3'b000,aluc,0));
        step({tag, ".aluwb"}, v(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.outs", {15'b0, outs}, 32'h0);
        check("rst.state", {28'b0, dut.state}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // lw: five cycles, register write from memory data in the last
        start("lw", 7'b0000011, 3'b010, 1'b0, 1'b0);
        decode("lw", 3'b010);
        step("lw.memadr", v(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
        step("lw.memread", v(0,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
        step("lw.memwb", v(0,0,0,0,2'b01,2'b00,2'b00,3'b000,3'b000,1));

        start("sw", 7'b0100011, 3'b010, 1'b0, 1'b0);
        decode("sw", 3'b010);
        step("sw.memadr", v(0,0,0,0,2'b00,2'b10,2'b01,3'b001,3'b000,0));
        step("sw.memwrite", v(0,1,1,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));

        run_alu("sub",  7'b0110011, 3'b000, 1'b1, 3'b001);
        run_alu("addi", 7'b0010011, 3'b000, 1'b1, 3'b000);
        run_alu("slt",  7'b0110011, 3'b010, 1'b0, 3'b101);
        run_alu("or",   7'b0110011, 3'b110, 1'b0, 3'b011);
        run_alu("andi", 7'b0010011, 3'b111, 1'b0, 3'b010);
        run_alu("sll",  7'b0110011, 3'b001, 1'b0, 3'b000);

        start("beqt", 7'b1100011, 3'b000, 1'b0, 1'b1);
        decode("beqt", 3'b010);
        step("beqt.beq", v(1,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b001,0));

        start("beqn", 7'b1100011, 3'b000, 1'b0, 1'b0);
        decode("beqn", 3'b010);
        step("beqn.beq", v(0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b001,0));

        start("jal", 7'b1101111, 3'b000, 1'b0, 1'b0);
        decode("jal", 3'b011);
        step("jal.jal", v(1,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b000,0));
        step("jal.aluwb", v(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1));

        start("ill", 7'b0000000, 3'b000, 1'b0, 1'b0);
        decode("ill", 3'b010);

        start("lui", 7'b0110111, 3'b000, 1'b0, 1'b0);
        decode("lui", 3'b010);
`ifdef UCSBECE154A_LUI_EN
        step("lui.lui", v(0,0,0,0,2'b11,2'b00,2'b00,3'b100,3'b000,1));
`endif

        // Asynchronous reset in MEMREAD drops the pending load writeback
        start("lwr", 7'b0000011, 3'b010, 1'b0, 1'b0);
        decode("lwr", 3'b010);
        step("lwr.memadr", v(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
        step("lwr.memread", v(0,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
        #2 reset = 1'b1;
        #1;
        check("lwr.rst.state", {28'b0, dut.state}, 32'd0);
        check("lwr.rst.outs", {15'b0, outs}, 32'h0);
        @(posedge clk);
        #1;
        check("lwr.rst.hold", {15'b0, outs}, 32'h0);
        reset = 1'b0;

        start("lw2", 7'b0000011, 3'b010, 1'b0, 1'b0);
        decode("lw2", 3'b010);
        step("lw2.memadr", v(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
        step("lw2.memread", v(0,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
        step("lw2.memwb", v(0,0,0,0,2'b01,2'b00,2'b00,3'b000,3'b000,1));
        step("end.fetch", v(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
